// File: rtl/csla_slice_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : csla_slice_sequencer
// Purpose  : Multi-cycle WIDTH-bit adder that time-multiplexes a single
//            SLICE-bit carry-select slice (ripple sum + binary-to-excess-1
//            converter) across the operand word, LSB slice first. The result
//            is written slice by slice into a held result register.
//            Latency: done pulses NSLICE+1 cycles after an accepted start.
//
// Parameters:
//   WIDTH  operand/result width (multiple of SLICE)
//   SLICE  bits added per cycle
//
// Ports:
//   clk    in   clock, all state on rising edge
//   rst    in   synchronous active-high reset
//   start  in   add request, sampled only while ready=1
//   a, b   in   operands, captured on accepted start
//   cin    in   carry-in, captured on accepted start
//   ready  out  high in IDLE only
//   sum    out  result, valid from done, held until next accepted start
//   cout   out  carry-out of bit WIDTH-1, same validity as sum
//   done   out  one-cycle pulse when sum/cout become valid
//   ovf    out  signed overflow (only when CSLA_SEQ_OVF_EN is defined)
//
// Build option:
//   CSLA_SEQ_OVF_EN  adds the ovf port and its overflow register.
//
// Revision : 1.0  initial release
// ============================================================================
module csla_slice_sequencer #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done
`ifdef CSLA_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    // Counter needs at least one bit even for a single-slice configuration.
    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NSLICE - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;
`ifdef CSLA_SEQ_OVF_EN
    logic             ovf_q,   ovf_d;
`endif

    // ------------------------------------------------------------------
    // Shared carry-select slice datapath
    // ------------------------------------------------------------------
    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE:0]   w_rsum;
    logic [SLICE-1:0] w_s0;
    logic             w_c0;
    logic [SLICE-1:0] w_s1;
    logic             w_c1;
    logic [SLICE-1:0] w_sel_s;
    logic             w_sel_c;

    assign w_a_sl = a_q[SLICE*int'(cnt_q) +: SLICE];
    assign w_b_sl = b_q[SLICE*int'(cnt_q) +: SLICE];

    // Carry-in-0 ripple sum of the current slice.
    assign w_rsum = {1'b0, w_a_sl} + {1'b0, w_b_sl};
    assign w_s0   = w_rsum[SLICE-1:0];
    assign w_c0   = w_rsum[SLICE];

    // Binary-to-excess-1 converter: s1 = s0 + 1 without a second adder.
    // Bit i flips when every lower bit of s0 is one.
    assign w_s1[0] = ~w_s0[0];
    for (genvar gi = 1; gi < SLICE; gi++) begin : g_bec
        assign w_s1[gi] = w_s0[gi] ^ (&w_s0[gi-1:0]);
    end
    // Incrementing s0 carries out only when s0 is all ones.
    assign w_c1 = w_c0 | (&w_s0);

    // The stored carry from the previous slice picks the precomputed pair.
    assign w_sel_s = carry_q ? w_s1 : w_s0;
    assign w_sel_c = carry_q ? w_c1 : w_c0;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef CSLA_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Slices above cnt_q keep the previous result until reached.
                sum_d[SLICE*int'(cnt_q) +: SLICE] = w_sel_s;
                carry_d = w_sel_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == C_LAST) begin
                    cout_d  = w_sel_c;
`ifdef CSLA_SEQ_OVF_EN
                    // Same-sign operands whose result sign differs.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (w_sel_s[SLICE-1] != a_q[WIDTH-1]);
`endif
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef CSLA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef CSLA_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // All outputs come straight from registers.
    assign ready = (state_q == S_IDLE);
    assign done  = (state_q == S_DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;
`ifdef CSLA_SEQ_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csla_slice_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_csla_slice_sequencer
// Purpose  : Directed self-checking bench for csla_slice_sequencer with
//            hand-computed sums, latency, handshake and reset scenarios.
//            Overflow cases are included when CSLA_SEQ_OVF_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_csla_slice_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        ready;
    logic [31:0] sum;
    logic        cout;
    logic        done;
`ifdef CSLA_SEQ_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    csla_slice_sequencer #(
        .WIDTH (32),
        .SLICE (4)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .sum   (sum),
        .cout  (cout),
        .done  (done)
`ifdef CSLA_SEQ_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Accept one add and wait (bounded) for done. lat counts edges after the
    // accepting edge up to the one after which done is seen high; a correct
    // design gives 8, i.e. done is high in the 9th cycle after acceptance.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic tc, output int acc_cyc, output int lat,
                          output logic [31:0] rs, output logic rc,
                          output logic ro);
        int guard;
        guard = 0;
        while (ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        acc_cyc = cyc;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = sum;
        rc = cout;
`ifdef CSLA_SEQ_OVF_EN
        ro = ovf;
`else
        ro = 1'b0;
`endif
    endtask

    task automatic test_reset;
        int seen;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0 || sum !== 32'h0 || cout !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: ready=%b done=%b sum=%h cout=%b, expected 1 0 00000000 0",
                     ready, done, sum, cout);
        end
`ifdef CSLA_SEQ_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ovf: got %b expected 0", ovf);
        end
`endif
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || ready !== 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL idle_quiet: %0d bad cycles (done high or ready low), expected 0", seen);
        end
    endtask

    task automatic test_basic;
        int acc, lat;
        logic [31:0] rs;
        logic rc, ro;
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, acc, lat, rs, rc, ro);
        n_checks++;
        if (lat != 8) begin
            n_errors++;
            $display("FAIL basic_latency: done after %0d edges, expected 8", lat);
        end
        n_checks++;
        if (rs !== 32'hACF13568 || rc !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_sum: got %h/%b expected acf13568/0", rs, rc);
        end
        n_checks++;
        if (ready !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_ready_during_done: got %b expected 0", ready);
        end
`ifdef CSLA_SEQ_OVF_EN
        n_checks++;
        if (ro !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_ovf: got %b expected 0", ro);
        end
`endif
        @(posedge clk); #1;
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0 || sum !== 32'hACF13568) begin
            n_errors++;
            $display("FAIL basic_after_done: ready=%b done=%b sum=%h expected 1 0 acf13568",
                     ready, done, sum);
        end
    endtask

    task automatic test_back_to_back;
        int t0, lat, acc, lat2;
        logic [31:0] rs;
        logic rc, ro;
        lat = 0;
        a = 32'h12345678; b = 32'h9ABCDEF0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            // Start pulse sampled at acceptance+3 while RUN: must be ignored.
            if (lat == 2) begin
                start = 1'b1; a = 32'hDEADBEEF; b = 32'h11111111; cin = 1'b1;
            end
            if (lat == 3) start = 1'b0;
        end
        n_checks++;
        if (lat != 8) begin
            n_errors++;
            $display("FAIL ignore_latency: done after %0d edges, expected 8", lat);
        end
        n_checks++;
        if (sum !== 32'hACF13568 || cout !== 1'b0) begin
            n_errors++;
            $display("FAIL ignore_sum: got %h/%b expected acf13568/0", sum, cout);
        end
        @(posedge clk); #1;
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL ignore_single_pulse: ready=%b done=%b expected 1 0", ready, done);
        end
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, acc, lat2, rs, rc, ro);
        n_checks++;
        if (acc - t0 != 10 || lat2 != 8) begin
            n_errors++;
            $display("FAIL b2b_timing: accept gap %0d latency %0d, expected 10 and 8",
                     acc - t0, lat2);
        end
        n_checks++;
        if (rs !== 32'h00000000 || rc !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_sum: got %h/%b expected 00000000/1", rs, rc);
        end
    endtask

`ifdef CSLA_SEQ_OVF_EN
    task automatic test_ovf;
        int acc, lat;
        logic [31:0] rs;
        logic rc, ro;
        run_op(32'h7FFFFFFF, 32'h00000000, 1'b1, acc, lat, rs, rc, ro);
        n_checks++;
        if (lat != 8 || rs !== 32'h80000000 || rc !== 1'b0 || ro !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_pos: lat=%0d sum=%h cout=%b ovf=%b expected 8 80000000 0 1",
                     lat, rs, rc, ro);
        end
        run_op(32'h80000000, 32'h80000000, 1'b0, acc, lat, rs, rc, ro);
        n_checks++;
        if (lat != 8 || rs !== 32'h00000000 || rc !== 1'b1 || ro !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_neg: lat=%0d sum=%h cout=%b ovf=%b expected 8 00000000 1 1",
                     lat, rs, rc, ro);
        end
    endtask
`endif

    task automatic test_carry;
        int acc, lat;
        logic [31:0] rs;
        logic rc, ro;
        run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, acc, lat, rs, rc, ro);
        n_checks++;
        if (lat != 8 || rs !== 32'h00000000 || rc !== 1'b1) begin
            n_errors++;
            $display("FAIL carry_cin_ripple: lat=%0d sum=%h cout=%b expected 8 00000000 1",
                     lat, rs, rc);
        end
        run_op(32'h0F0F0F0F, 32'h01010101, 1'b1, acc, lat, rs, rc, ro);
        n_checks++;
        if (rs !== 32'h10101011 || rc !== 1'b0) begin
            n_errors++;
            $display("FAIL carry_mixed: got %h/%b expected 10101011/0", rs, rc);
        end
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, acc, lat, rs, rc, ro);
        n_checks++;
        if (rs !== 32'hFFFFFFFF || rc !== 1'b1) begin
            n_errors++;
            $display("FAIL carry_all_ones: got %h/%b expected ffffffff/1", rs, rc);
        end
    endtask

    task automatic test_reset_mid_run;
        int seen, acc, lat;
        logic [31:0] rs;
        logic rc, ro;
        a = 32'h0F0F0F0F; b = 32'h01010101; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        // Sampled at acceptance+4, in the middle of RUN.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (ready !== 1'b1 || sum !== 32'h0 || cout !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL midrun_reset: ready=%b sum=%h cout=%b done=%b expected 1 00000000 0 0",
                     ready, sum, cout, done);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL midrun_no_done: %0d done cycles, expected 0", seen);
        end
        run_op(32'h0F0F0F0F, 32'h01010101, 1'b1, acc, lat, rs, rc, ro);
        n_checks++;
        if (lat != 8 || rs !== 32'h10101011 || rc !== 1'b0) begin
            n_errors++;
            $display("FAIL midrun_restart: lat=%0d sum=%h cout=%b expected 8 10101011 0",
                     lat, rs, rc);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
`ifdef CSLA_SEQ_OVF_EN
        test_ovf();
`endif
        test_carry();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
